// File: rtl/riscv_if_parcel_queue.sv
// Parcel queue between the instruction-cache FSM and decode: buffers 16-bit parcels
// in a circular FIFO and re-assembles one RVC or 32-bit instruction per cycle.
module riscv_if_parcel_queue #(
    parameter int XLEN        = 32,
    parameter int PARCEL_SIZE = 16,
    parameter bit HAS_RVC     = 1'b1,
    parameter int DEPTH       = 8
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              flush_i,
    input  logic [XLEN-1:0]                   parcel_i,
    input  logic [XLEN/PARCEL_SIZE-1:0]       parcel_valid_i,
    input  logic [XLEN-1:0]                   parcel_pc_i,
    input  logic                              parcel_error_i,
    input  logic                              parcel_misaligned_i,
    input  logic                              parcel_pagefault_i,
    output logic                              almost_full_o,
    output logic                              empty_o,
    output logic                              overflow_o,
    output logic [31:0]                       instr_o,
    output logic [XLEN-1:0]                   instr_pc_o,
    output logic                              instr_valid_o,
    output logic                              instr_rvc_o,
    output logic                              instr_error_o,
    output logic                              instr_misaligned_o,
    output logic                              instr_pagefault_o,
    input  logic                              instr_rdy_i
);

    localparam int NP    = XLEN / PARCEL_SIZE;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] NP_C    = CNT_W'(NP);

    logic [PARCEL_SIZE-1:0] parcel_q [DEPTH];
    logic [XLEN-1:0]        pc_q     [DEPTH];
    logic [DEPTH-1:0]       err_q;
    logic [DEPTH-1:0]       mis_q;
    logic [DEPTH-1:0]       pf_q;
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [CNT_W-1:0]       count_q;
    logic                   overflow_q;

    logic                   any_flag;
    logic [CNT_W-1:0]       need;
    logic [CNT_W-1:0]       free_cnt;
    logic                   push_ok;
    logic [PTR_W-1:0]       off;
    logic [NP-1:0]          wen;
    logic [PTR_W-1:0]       widx    [NP];
    logic [PARCEL_SIZE-1:0] wparcel [NP];
    logic [XLEN-1:0]        wpc     [NP];

    // Valid parcels are packed into consecutive slots; a flag-only fetch still takes one slot
    // so the fault reaches decode with the fetch PC.
    always_comb begin
        any_flag = parcel_error_i | parcel_misaligned_i | parcel_pagefault_i;
        free_cnt = DEPTH_C - count_q;
        need     = '0;
        off      = '0;
        wen      = '0;
        for (int i = 0; i < NP; i++) begin
            widx[i]    = wr_ptr_q;
            wparcel[i] = parcel_i[i*PARCEL_SIZE +: PARCEL_SIZE];
            wpc[i]     = {parcel_pc_i[XLEN-1:2], 2'b00};
            wpc[i][1]  = i[0];
            if (parcel_valid_i[i]) begin
                wen[i]  = 1'b1;
                widx[i] = wr_ptr_q + off;
                off     = off + PTR_W'(1);
                need    = need + CNT_W'(1);
            end
        end
        if (parcel_valid_i == '0 && any_flag) begin
            wen[0]     = 1'b1;
            widx[0]    = wr_ptr_q;
            wparcel[0] = '0;
            wpc[0]     = parcel_pc_i;
            need       = CNT_W'(1);
        end
        push_ok = !flush_i && (need != '0) && (need <= free_cnt);
    end

    logic [PTR_W-1:0] h1_ptr;
    logic             head_flag;
    logic             head_is16;
    logic             pop;
    logic [CNT_W-1:0] pop_n;

    // A flagged head is always delivered alone so the fault is reported without
    // waiting for a second parcel that may never arrive.
    always_comb begin
        h1_ptr      = rd_ptr_q + PTR_W'(1);
        head_flag   = err_q[rd_ptr_q] | mis_q[rd_ptr_q] | pf_q[rd_ptr_q];
        head_is16   = head_flag || (HAS_RVC && parcel_q[rd_ptr_q][1:0] != 2'b11);
        instr_pc_o  = pc_q[rd_ptr_q];
        instr_rvc_o = head_is16;
        if (head_is16) begin
            instr_valid_o      = !flush_i && (count_q >= CNT_W'(1));
            instr_o            = 32'(parcel_q[rd_ptr_q]);
            instr_error_o      = err_q[rd_ptr_q];
            instr_misaligned_o = mis_q[rd_ptr_q];
            instr_pagefault_o  = pf_q[rd_ptr_q];
            pop_n              = CNT_W'(1);
        end else begin
            instr_valid_o      = !flush_i && (count_q >= CNT_W'(2));
            instr_o            = 32'({parcel_q[h1_ptr], parcel_q[rd_ptr_q]});
            instr_error_o      = err_q[rd_ptr_q] | err_q[h1_ptr];
            instr_misaligned_o = mis_q[rd_ptr_q] | mis_q[h1_ptr];
            instr_pagefault_o  = pf_q[rd_ptr_q]  | pf_q[h1_ptr];
            pop_n              = CNT_W'(2);
        end
        pop = instr_valid_o & instr_rdy_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            err_q      <= '0;
            mis_q      <= '0;
            pf_q       <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                parcel_q[j] <= '0;
                pc_q[j]     <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            // Space is judged against the pre-pop count, so a same-cycle pop never rescues a push.
            overflow_q <= (need != '0) && !push_ok;
            if (push_ok) begin
                for (int i = 0; i < NP; i++) begin
                    if (wen[i]) begin
                        parcel_q[widx[i]] <= wparcel[i];
                        pc_q[widx[i]]     <= wpc[i];
                        err_q[widx[i]]    <= parcel_error_i;
                        mis_q[widx[i]]    <= parcel_misaligned_i;
                        pf_q[widx[i]]     <= parcel_pagefault_i;
                    end
                end
                wr_ptr_q <= wr_ptr_q + PTR_W'(need);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(pop_n);
            end
            count_q <= count_q + (push_ok ? need : '0) - (pop ? pop_n : '0);
        end
    end

    assign overflow_o    = overflow_q;
    assign empty_o       = (count_q == '0);
    assign almost_full_o = (free_cnt < NP_C);

endmodule
